// File: rtl/lsu_wb.sv
// -----------------------------------------------------------------------------
// lsu_wb : load/store + writeback stage between EXU and the register file.
//
// Takes one op at a time from EXU (ALU pass-through, load or store). Loads and
// stores run a req/ack transaction to data memory, bounded by a timeout.
// The stage owns the single registered writeback port into the register file
// and a registered error pulse.
//
// Handshake rules:
//   EXU -> LSU : an op transfers on a cycle where exu_lsu_vld & lsu_exu_rdy are
//                both high; EXU holds all op fields stable until then.
//   LSU -> MEM : lsu_mem_req and every lsu_mem_* field stay constant from the
//                first request cycle up to and including the cycle that
//                mem_lsu_ack is high. mem_lsu_rdata is sampled only in the
//                ack cycle. An ack outside a request is ignored.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   exu_lsu_*              op from EXU (vld/op/funct3/addr/alu_res/st_data/rd)
//   lsu_exu_rdy            high while IDLE
//   lsu_mem_*              memory request (req/we/addr/wdata/wstrb)
//   mem_lsu_ack/rdata      memory response
//   lsu_rf_wb_*            1-cycle writeback pulse (suppressed for rd == 0)
//   lsu_err_vld/code       1-cycle error pulse: 01 misaligned, 10 timeout,
//                          11 illegal funct3
//   dbg_state              current FSM state (0 IDLE, 1 MEM)
// -----------------------------------------------------------------------------
module lsu_wb #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exu_lsu_vld,
    output logic        lsu_exu_rdy,
    input  logic [1:0]  exu_lsu_op,
    input  logic [2:0]  exu_lsu_funct3,
    input  logic [31:0] exu_lsu_addr,
    input  logic [31:0] exu_lsu_alu_res,
    input  logic [31:0] exu_lsu_st_data,
    input  logic [4:0]  exu_lsu_rd,
    output logic        lsu_mem_req,
    output logic        lsu_mem_we,
    output logic [31:0] lsu_mem_addr,
    output logic [31:0] lsu_mem_wdata,
    output logic [3:0]  lsu_mem_wstrb,
    input  logic        mem_lsu_ack,
    input  logic [31:0] mem_lsu_rdata,
    output logic        lsu_rf_wb_vld,
    output logic [4:0]  lsu_rf_wb_addr,
    output logic [31:0] lsu_rf_wb_data,
    output logic        lsu_err_vld,
    output logic [1:0]  lsu_err_code,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1
    } state_t;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;

    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_F3    = 2'b11;

    // Last counter value that is still allowed to wait for an ack.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [4:0]        r_rd;
    logic [2:0]        r_f3;
    logic [1:0]        r_lane;
    logic              r_wb_vld;
    logic [4:0]        r_wb_addr;
    logic [31:0]       r_wb_data;
    logic              r_err_vld;
    logic [1:0]        r_err_code;

    logic              w_accept;
    logic              w_is_st;
    logic              w_f3_ok;
    logic              w_misal;
    logic [31:0]       w_st_wdata;
    logic [3:0]        w_st_wstrb;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [31:0]       w_ld_data;

    assign lsu_exu_rdy = (r_state == ST_IDLE);
    assign w_accept    = exu_lsu_vld & lsu_exu_rdy;
    assign w_is_st     = (exu_lsu_op == OP_ST);

    // funct3 legality: loads allow B/H/W/BU/HU, stores only B/H/W.
    always_comb begin
        w_f3_ok = 1'b0;
        if (w_is_st) begin
            w_f3_ok = (exu_lsu_funct3 == 3'b000) || (exu_lsu_funct3 == 3'b001) ||
                      (exu_lsu_funct3 == 3'b010);
        end else begin
            w_f3_ok = (exu_lsu_funct3 == 3'b000) || (exu_lsu_funct3 == 3'b001) ||
                      (exu_lsu_funct3 == 3'b010) || (exu_lsu_funct3 == 3'b100) ||
                      (exu_lsu_funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes the access size for both signed and unsigned forms.
    assign w_misal = ((exu_lsu_funct3[1:0] == 2'b01) && exu_lsu_addr[0]) ||
                     ((exu_lsu_funct3[1:0] == 2'b10) && (exu_lsu_addr[1:0] != 2'b00));

    // Store data is replicated across lanes so the strobes alone pick the bytes.
    always_comb begin
        w_st_wdata = exu_lsu_st_data;
        w_st_wstrb = 4'b1111;
        case (exu_lsu_funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{exu_lsu_st_data[7:0]}};
                w_st_wstrb = 4'b0001 << exu_lsu_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{exu_lsu_st_data[15:0]}};
                w_st_wstrb = exu_lsu_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_wdata = exu_lsu_st_data;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane select and sign/zero extension from the saved address bits.
    always_comb begin
        w_ld_byte = mem_lsu_rdata[7:0];
        case (r_lane)
            2'd0:    w_ld_byte = mem_lsu_rdata[7:0];
            2'd1:    w_ld_byte = mem_lsu_rdata[15:8];
            2'd2:    w_ld_byte = mem_lsu_rdata[23:16];
            default: w_ld_byte = mem_lsu_rdata[31:24];
        endcase
        w_ld_half = r_lane[1] ? mem_lsu_rdata[31:16] : mem_lsu_rdata[15:0];
        case (r_f3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = mem_lsu_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rd       <= '0;
            r_f3       <= '0;
            r_lane     <= '0;
            r_wb_vld   <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_err_vld  <= 1'b0;
            r_err_code <= '0;
        end else begin
            // Writeback and error are single-cycle pulses.
            r_wb_vld  <= 1'b0;
            r_err_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (exu_lsu_op)
                            OP_ALU: begin
                                if (exu_lsu_rd != 5'd0) begin
                                    r_wb_vld  <= 1'b1;
                                    r_wb_addr <= exu_lsu_rd;
                                    r_wb_data <= exu_lsu_alu_res;
                                end
                            end
                            OP_LD, OP_ST: begin
                                if (!w_f3_ok) begin
                                    r_err_vld  <= 1'b1;
                                    r_err_code <= ERR_F3;
                                end else if (w_misal) begin
                                    r_err_vld  <= 1'b1;
                                    r_err_code <= ERR_MISAL;
                                end else begin
                                    r_req   <= 1'b1;
                                    r_we    <= w_is_st;
                                    r_addr  <= {exu_lsu_addr[31:2], 2'b00};
                                    r_wdata <= w_is_st ? w_st_wdata : 32'd0;
                                    r_wstrb <= w_is_st ? w_st_wstrb : 4'b0000;
                                    r_rd    <= exu_lsu_rd;
                                    r_f3    <= exu_lsu_funct3;
                                    r_lane  <= exu_lsu_addr[1:0];
                                    r_cnt   <= '0;
                                    r_state <= ST_MEM;
                                end
                            end
                            default: ; // reserved op: consumed with no effect
                        endcase
                    end
                end
                ST_MEM: begin
                    // Ack is checked first so an ack on the boundary cycle wins.
                    if (mem_lsu_ack) begin
                        r_req   <= 1'b0;
                        r_state <= ST_IDLE;
                        if (!r_we && (r_rd != 5'd0)) begin
                            r_wb_vld  <= 1'b1;
                            r_wb_addr <= r_rd;
                            r_wb_data <= w_ld_data;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_req      <= 1'b0;
                        r_state    <= ST_IDLE;
                        r_err_vld  <= 1'b1;
                        r_err_code <= ERR_TMO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign lsu_mem_req    = r_req;
    assign lsu_mem_we     = r_we;
    assign lsu_mem_addr   = r_addr;
    assign lsu_mem_wdata  = r_wdata;
    assign lsu_mem_wstrb  = r_wstrb;
    assign lsu_rf_wb_vld  = r_wb_vld;
    assign lsu_rf_wb_addr = r_wb_addr;
    assign lsu_rf_wb_data = r_wb_data;
    assign lsu_err_vld    = r_err_vld;
    assign lsu_err_code   = r_err_code;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_lsu_wb.sv
// -----------------------------------------------------------------------------
// tb_lsu_wb : bench for lsu_wb (instantiated with TIMEOUT_CYC = 4).
// A vector table drives single ops; expected writebacks and errors are queued
// when an op is driven and popped by a monitor when the DUT pulses them.
// Hand-written sequences cover back-to-back ALU ops, ack while idle and
// reset during a memory transaction.
// -----------------------------------------------------------------------------
module tb_lsu_wb;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        exu_lsu_vld;
    logic        lsu_exu_rdy;
    logic [1:0]  exu_lsu_op;
    logic [2:0]  exu_lsu_funct3;
    logic [31:0] exu_lsu_addr;
    logic [31:0] exu_lsu_alu_res;
    logic [31:0] exu_lsu_st_data;
    logic [4:0]  exu_lsu_rd;
    logic        lsu_mem_req;
    logic        lsu_mem_we;
    logic [31:0] lsu_mem_addr;
    logic [31:0] lsu_mem_wdata;
    logic [3:0]  lsu_mem_wstrb;
    logic        mem_lsu_ack;
    logic [31:0] mem_lsu_rdata;
    logic        lsu_rf_wb_vld;
    logic [4:0]  lsu_rf_wb_addr;
    logic [31:0] lsu_rf_wb_data;
    logic        lsu_err_vld;
    logic [1:0]  lsu_err_code;
    logic [1:0]  dbg_state;

    lsu_wb #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .exu_lsu_vld     (exu_lsu_vld),
        .lsu_exu_rdy     (lsu_exu_rdy),
        .exu_lsu_op      (exu_lsu_op),
        .exu_lsu_funct3  (exu_lsu_funct3),
        .exu_lsu_addr    (exu_lsu_addr),
        .exu_lsu_alu_res (exu_lsu_alu_res),
        .exu_lsu_st_data (exu_lsu_st_data),
        .exu_lsu_rd      (exu_lsu_rd),
        .lsu_mem_req     (lsu_mem_req),
        .lsu_mem_we      (lsu_mem_we),
        .lsu_mem_addr    (lsu_mem_addr),
        .lsu_mem_wdata   (lsu_mem_wdata),
        .lsu_mem_wstrb   (lsu_mem_wstrb),
        .mem_lsu_ack     (mem_lsu_ack),
        .mem_lsu_rdata   (mem_lsu_rdata),
        .lsu_rf_wb_vld   (lsu_rf_wb_vld),
        .lsu_rf_wb_addr  (lsu_rf_wb_addr),
        .lsu_rf_wb_data  (lsu_rf_wb_data),
        .lsu_err_vld     (lsu_err_vld),
        .lsu_err_code    (lsu_err_code),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];      // {rd, data} of expected writebacks
    logic [1:0]  exp_err_q[$];  // expected error codes

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [36:0] e;
        if (lsu_rf_wb_vld) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", {31'd0, lsu_rf_wb_vld}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", {27'd0, lsu_rf_wb_addr}, {27'd0, e[36:32]});
                check("wb_data", lsu_rf_wb_data, e[31:0]);
            end
        end
        if (lsu_err_vld) begin
            if (exp_err_q.size() == 0) begin
                check("err_unexpected", {31'd0, lsu_err_vld}, 32'd0);
            end else begin
                check("err_code", {30'd0, lsu_err_code}, {30'd0, exp_err_q.pop_front()});
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] alu_res;
        logic [31:0] st_data;
        logic [4:0]  rd;
        int          ack_k;     // ack in the k-th request cycle, 0 = never
        logic [31:0] rdata;
        logic        e_wb;
        logic [31:0] e_wb_data;
        logic        e_err;
        logic [1:0]  e_code;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_maddr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
        input logic [31:0] alu_res, input logic [31:0] st_data, input logic [4:0] rd,
        input int ack_k, input logic [31:0] rdata,
        input logic e_wb, input logic [31:0] e_wb_data,
        input logic e_err, input logic [1:0] e_code,
        input logic e_req, input logic e_we, input logic [31:0] e_maddr,
        input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
        vec_t v;
        v.op = op; v.f3 = f3; v.addr = addr; v.alu_res = alu_res; v.st_data = st_data;
        v.rd = rd; v.ack_k = ack_k; v.rdata = rdata;
        v.e_wb = e_wb; v.e_wb_data = e_wb_data; v.e_err = e_err; v.e_code = e_code;
        v.e_req = e_req; v.e_we = e_we; v.e_maddr = e_maddr; v.e_wdata = e_wdata;
        v.e_wstrb = e_wstrb;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic do_op(input int idx);
        vec_t v;
        int   n;
        int   exp_n;
        v = vecs[idx];
        n = 0;
        while (!lsu_exu_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rdy_before_op", {31'd0, lsu_exu_rdy}, 32'd1);
        exu_lsu_vld     = 1'b1;
        exu_lsu_op      = v.op;
        exu_lsu_funct3  = v.f3;
        exu_lsu_addr    = v.addr;
        exu_lsu_alu_res = v.alu_res;
        exu_lsu_st_data = v.st_data;
        exu_lsu_rd      = v.rd;
        if (v.e_wb)  exp_q.push_back({v.rd, v.e_wb_data});
        if (v.e_err) exp_err_q.push_back(v.e_code);
        @(negedge clk);
        exu_lsu_vld     = 1'b0;
        exu_lsu_alu_res = $urandom;
        exu_lsu_st_data = $urandom;
        exp_n = v.e_req ? ((v.ack_k > 0) ? v.ack_k : TO) : 0;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!lsu_mem_req) break;
            n++;
            check("mem_we", {31'd0, lsu_mem_we}, {31'd0, v.e_we});
            check("mem_addr", lsu_mem_addr, v.e_maddr);
            check("mem_wstrb", {28'd0, lsu_mem_wstrb}, {28'd0, v.e_wstrb});
            if (v.e_we) check("mem_wdata", lsu_mem_wdata, v.e_wdata);
            check("rdy_in_mem", {31'd0, lsu_exu_rdy}, 32'd0);
            if (c == v.ack_k) begin
                mem_lsu_ack   = 1'b1;
                mem_lsu_rdata = v.rdata;
            end else begin
                mem_lsu_rdata = $urandom;
            end
            @(negedge clk);
            mem_lsu_ack = 1'b0;
        end
        check("req_cycles", n, exp_n);
        check("rdy_after_op", {31'd0, lsu_exu_rdy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- test ----------------
    initial begin
        //           op    f3     addr          alu           st            rd  k  rdata         wb  wbdata        err code  req we maddr         wdata         wstrb
        vecs[0]  = mk(2'd0, 3'd0, 32'h0,        32'hDEADBEEF, 32'h0,        5,  0, 32'h0,        1, 32'hDEADBEEF, 0, 2'd0, 0, 0, 32'h0,        32'h0,        4'h0);
        vecs[1]  = mk(2'd0, 3'd0, 32'h0,        32'h12345678, 32'h0,        0,  0, 32'h0,        0, 32'h0,        0, 2'd0, 0, 0, 32'h0,        32'h0,        4'h0);
        vecs[2]  = mk(2'd1, 3'd0, 32'h1003,     32'h0,        32'h0,        7,  3, 32'h80112233, 1, 32'hFFFFFF80, 0, 2'd0, 1, 0, 32'h1000,     32'h0,        4'h0);
        vecs[3]  = mk(2'd1, 3'd4, 32'h1003,     32'h0,        32'h0,        8,  3, 32'h80112233, 1, 32'h00000080, 0, 2'd0, 1, 0, 32'h1000,     32'h0,        4'h0);
        vecs[4]  = mk(2'd2, 3'd1, 32'h2002,     32'h0,        32'h0000ABCD, 9,  2, 32'h0,        0, 32'h0,        0, 2'd0, 1, 1, 32'h2000,     32'hABCDABCD, 4'hC);
        vecs[5]  = mk(2'd1, 3'd2, 32'h3001,     32'h0,        32'h0,        4,  0, 32'h0,        0, 32'h0,        1, 2'd1, 0, 0, 32'h0,        32'h0,        4'h0);
        vecs[6]  = mk(2'd1, 3'd3, 32'h3000,     32'h0,        32'h0,        4,  0, 32'h0,        0, 32'h0,        1, 2'd3, 0, 0, 32'h0,        32'h0,        4'h0);
        vecs[7]  = mk(2'd1, 3'd2, 32'h4000,     32'h0,        32'h0,        10, 0, 32'h0,        0, 32'h0,        1, 2'd2, 1, 0, 32'h4000,     32'h0,        4'h0);
        vecs[8]  = mk(2'd1, 3'd2, 32'h4004,     32'h0,        32'h0,        11, 4, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 2'd0, 1, 0, 32'h4004,     32'h0,        4'h0);
        vecs[9]  = mk(2'd1, 3'd1, 32'h5002,     32'h0,        32'h0,        12, 1, 32'h80017FFF, 1, 32'hFFFF8001, 0, 2'd0, 1, 0, 32'h5000,     32'h0,        4'h0);
        vecs[10] = mk(2'd1, 3'd5, 32'h5000,     32'h0,        32'h0,        13, 1, 32'h8001F00F, 1, 32'h0000F00F, 0, 2'd0, 1, 0, 32'h5000,     32'h0,        4'h0);
        vecs[11] = mk(2'd2, 3'd0, 32'h6001,     32'h0,        32'h123456A5, 0,  1, 32'h0,        0, 32'h0,        0, 2'd0, 1, 1, 32'h6000,     32'hA5A5A5A5, 4'h2);
        vecs[12] = mk(2'd2, 3'd2, 32'h6004,     32'h0,        32'h11223344, 15, 1, 32'h0,        0, 32'h0,        0, 2'd0, 1, 1, 32'h6004,     32'h11223344, 4'hF);
        vecs[13] = mk(2'd2, 3'd4, 32'h6000,     32'h0,        32'h55555555, 2,  0, 32'h0,        0, 32'h0,        1, 2'd3, 0, 0, 32'h0,        32'h0,        4'h0);
        vecs[14] = mk(2'd2, 3'd1, 32'h6003,     32'h0,        32'h66666666, 2,  0, 32'h0,        0, 32'h0,        1, 2'd1, 0, 0, 32'h0,        32'h0,        4'h0);
        vecs[15] = mk(2'd3, 3'd0, 32'h0,        32'hAAAA5555, 32'h0,        3,  0, 32'h0,        0, 32'h0,        0, 2'd0, 0, 0, 32'h0,        32'h0,        4'h0);
        vecs[16] = mk(2'd1, 3'd0, 32'h7001,     32'h0,        32'h0,        0,  2, 32'h0000AB00, 0, 32'h0,        0, 2'd0, 1, 0, 32'h7000,     32'h0,        4'h0);
        vecs[17] = mk(2'd1, 3'd1, 32'h7001,     32'h0,        32'h0,        6,  0, 32'h0,        0, 32'h0,        1, 2'd1, 0, 0, 32'h0,        32'h0,        4'h0);
        vecs[18] = mk(2'd1, 3'd0, 32'h7002,     32'h0,        32'h0,        16, 1, 32'h00FE0000, 1, 32'hFFFFFFFE, 0, 2'd0, 1, 0, 32'h7000,     32'h0,        4'h0);

        rst_n           = 1'b0;
        exu_lsu_vld     = 1'b0;
        exu_lsu_op      = 2'd0;
        exu_lsu_funct3  = 3'd0;
        exu_lsu_addr    = 32'd0;
        exu_lsu_alu_res = 32'd0;
        exu_lsu_st_data = 32'd0;
        exu_lsu_rd      = 5'd0;
        mem_lsu_ack     = 1'b0;
        mem_lsu_rdata   = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, lsu_mem_req}, 32'd0);
        check("rst_wb_vld", {31'd0, lsu_rf_wb_vld}, 32'd0);
        check("rst_err_vld", {31'd0, lsu_err_vld}, 32'd0);
        check("rst_rdy", {31'd0, lsu_exu_rdy}, 32'd1);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single ops
        for (int i = 0; i < NV; i++) do_op(i);

        // Back-to-back ALU ops: one writeback per cycle, rdy stays high
        for (int i = 0; i < 4; i++) begin
            logic [31:0] r;
            r = $urandom;
            exu_lsu_vld     = 1'b1;
            exu_lsu_op      = 2'd0;
            exu_lsu_rd      = 5'(20 + i);
            exu_lsu_alu_res = r;
            exp_q.push_back({5'(20 + i), r});
            check("b2b_rdy", {31'd0, lsu_exu_rdy}, 32'd1);
            @(negedge clk);
        end
        exu_lsu_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Ack while idle has no effect
        mem_lsu_ack   = 1'b1;
        mem_lsu_rdata = 32'h12345678;
        @(negedge clk);
        mem_lsu_ack = 1'b0;
        check("idle_ack_req", {31'd0, lsu_mem_req}, 32'd0);
        check("idle_ack_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);

        // Reset asserted mid-transaction
        exu_lsu_vld    = 1'b1;
        exu_lsu_op     = 2'd1;
        exu_lsu_funct3 = 3'd2;
        exu_lsu_addr   = 32'h8000;
        exu_lsu_rd     = 5'd14;
        @(negedge clk);
        exu_lsu_vld = 1'b0;
        check("pre_rst_req", {31'd0, lsu_mem_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, lsu_mem_req}, 32'd0);
        check("async_rst_rdy", {31'd0, lsu_exu_rdy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_req", {31'd0, lsu_mem_req}, 32'd0);
        check("post_rst_state", {30'd0, dbg_state}, 32'd0);

        // Every expected writeback/error must have been seen
        repeat (3) @(negedge clk);
        check("wb_q_empty", exp_q.size(), 32'd0);
        check("err_q_empty", exp_err_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
